// File: rtl/div16s8s_pkg.sv
// rtl/div16s8s_pkg.sv - shared widths, latency and FSM state type for the 16/8 signed divider
package div16s8s_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int LATENCY    = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_step_u17.sv
// rtl/div_step_u17.sv - one restoring division step on the unsigned magnitudes
module div_step_u17
  import div16s8s_pkg::*;
(
  input  logic [DIVISOR_W-1:0]  rem_in,
  input  logic [DIVIDEND_W:0]   num_in,
  input  logic [DIVISOR_W-1:0]  dvs,
  output logic [DIVISOR_W-1:0]  rem_out,
  output logic [DIVIDEND_W:0]   num_out
);

  logic [DIVISOR_W:0]   shifted;
  logic [DIVISOR_W-1:0] diff;
  logic                 fits;

  // Partial remainder stays below the divisor magnitude (<= 128), so 8 bits suffice;
  // the low 8 bits of the difference are exact whenever the subtraction fits.
  always_comb begin
    shifted = {rem_in, num_in[DIVIDEND_W-1]};
    fits    = (shifted >= {1'b0, dvs});
    diff    = shifted[DIVISOR_W-1:0] - dvs;
    rem_out = fits ? diff : shifted[DIVISOR_W-1:0];
    num_out = {num_in[DIVIDEND_W], num_in[DIVIDEND_W-2:0], fits};
  end

endmodule

// File: rtl/div16s8s_seq.sv
// rtl/div16s8s_seq.sv - sequential signed 16/8 divider, fixed 17-cycle latency, ready/valid handshake
module div16s8s_seq
  import div16s8s_pkg::*;
#(
  parameter int LATENCY = div16s8s_pkg::LATENCY
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  localparam logic [3:0] LAST_STEP = 4'(LATENCY - 2);

  state_t      state, next_state;
  logic [3:0]  count;
  logic [16:0] num;
  logic [7:0]  rem;
  logic [7:0]  dvs_mag;
  logic [7:0]  low_byte;
  logic        q_neg, r_neg, dz, ov;

  logic [16:0] dvd_ext, dvd_mag;
  logic [7:0]  dvs_abs;
  logic [16:0] step_num;
  logic [7:0]  step_rem;

  div_step_u17 u_step (
    .rem_in  (rem),
    .num_in  (num),
    .dvs     (dvs_mag),
    .rem_out (step_rem),
    .num_out (step_num)
  );

  // 17-bit magnitude so that -32768 maps cleanly to +32768.
  always_comb begin
    dvd_ext = {dividend[15], dividend};
    dvd_mag = dvd_ext[16] ? (~dvd_ext + 17'd1) : dvd_ext;
    dvs_abs = divisor[7] ? (~divisor + 8'd1) : divisor;
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid) next_state = CALC;
      CALC: if (count == LAST_STEP) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      num         <= '0;
      rem         <= '0;
      dvs_mag     <= '0;
      low_byte    <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dz          <= 1'b0;
      ov          <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            num      <= dvd_mag;
            rem      <= '0;
            dvs_mag  <= dvs_abs;
            low_byte <= dividend[7:0];
            q_neg    <= dividend[15] ^ divisor[7];
            r_neg    <= dividend[15];
            dz       <= (divisor == 8'd0);
            ov       <= (dividend == 16'h8000) && (divisor == 8'hFF);
            count    <= '0;
          end
        end
        CALC: begin
          num   <= step_num;
          rem   <= step_rem;
          count <= count + 4'd1;
        end
        FIX: begin
          out_valid   <= 1'b1;
          div_by_zero <= dz;
          overflow    <= ov;
          if (dz) begin
            quotient  <= 16'hFFFF;
            remainder <= low_byte;
          end else if (ov) begin
            quotient  <= 16'h8000;
            remainder <= 8'h00;
          end else begin
            quotient  <= q_neg ? (~num[15:0] + 16'd1) : num[15:0];
            remainder <= r_neg ? (~rem + 8'd1) : rem;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
